// File: rtl/fifo_sync_param.sv
// Synchronous circular FIFO with a registered read port, occupancy count,
// programmable almost-full/almost-empty decodes and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int Data      = 512,
  parameter int Adbus     = 3,
  parameter int AF_Margin = 1,
  parameter int AE_Margin = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr_err,
  input  logic [Data-1:0]  Data_in,
  output logic [Data-1:0]  Data_out,
  output logic             Data_valid,
  output logic [Adbus:0]   count,
  output logic             In_Busy,
  output logic             Out_Busy,
  output logic             In_Almost_Full,
  output logic             Out_Almost_Empty,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int DEPTH = 1 << Adbus;
  localparam logic [Adbus:0] DEPTH_C  = (Adbus+1)'(DEPTH);
  localparam logic [Adbus:0] AF_THR_C = (Adbus+1)'(DEPTH - AF_Margin);
  localparam logic [Adbus:0] AE_THR_C = (Adbus+1)'(AE_Margin);

  logic [Data-1:0]  mem_q [DEPTH];
  logic [Adbus-1:0] wr_addr_q, wr_addr_d;
  logic [Adbus-1:0] rd_addr_q, rd_addr_d;
  logic [Adbus:0]   count_q, count_d;
  logic [Data-1:0]  dout_q;
  logic             valid_q;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_acc, wr_acc, mem_we;

  always_comb begin
    rd_acc    = rd_en && (count_q != '0);
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc    = wr_en && ((count_q != DEPTH_C) || rd_en);
    mem_we    = wr_acc && !rst;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    count_d   = count_q;
    if (wr_acc) wr_addr_d = wr_addr_q + 1'b1;
    if (rd_acc) rd_addr_d = rd_addr_q + 1'b1;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    // A new error in the same cycle as clr_err leaves the flag set.
    ovf_d = (ovf_q && !clr_err) || (wr_en && !wr_acc);
    unf_d = (unf_q && !clr_err) || (rd_en && !rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
      valid_q   <= rd_acc;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      if (rd_acc) dout_q <= mem_q[rd_addr_q];
    end
  end

  // Storage carries no reset so it maps onto block RAM; read-before-write on a shared slot.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_q] <= Data_in;
  end

  assign Data_out         = dout_q;
  assign Data_valid       = valid_q;
  assign count            = count_q;
  assign In_Busy          = (count_q == DEPTH_C);
  assign Out_Busy         = (count_q == '0);
  assign In_Almost_Full   = (count_q >= AF_THR_C);
  assign Out_Almost_Empty = (count_q <= AE_THR_C);
  assign Overflow         = ovf_q;
  assign Underflow        = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (16-bit data, 8 entries).
module tb_fifo_sync_param;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr_err;
  logic [DW-1:0] Data_in, Data_out;
  logic          Data_valid;
  logic [AW:0]   count;
  logic          In_Busy, Out_Busy, In_Almost_Full, Out_Almost_Empty, Overflow, Underflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_sync_param #(.Data(DW), .Adbus(AW), .AF_Margin(1), .AE_Margin(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .Data_in(Data_in), .Data_out(Data_out), .Data_valid(Data_valid), .count(count),
    .In_Busy(In_Busy), .Out_Busy(Out_Busy), .In_Almost_Full(In_Almost_Full),
    .Out_Almost_Empty(Out_Almost_Empty), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_count"}, 32'(count), 0);
    check_eq({tag, "_empty"}, 32'(Out_Busy), 1);
    check_eq({tag, "_full"},  32'(In_Busy), 0);
    check_eq({tag, "_ae"},    32'(Out_Almost_Empty), 1);
    check_eq({tag, "_af"},    32'(In_Almost_Full), 0);
    check_eq({tag, "_dout"},  32'(Data_out), 0);
    check_eq({tag, "_valid"}, 32'(Data_valid), 0);
    check_eq({tag, "_ovf"},   32'(Overflow), 0);
    check_eq({tag, "_unf"},   32'(Underflow), 0);
  endtask

  logic [DW-1:0] drain_exp [8];
  int exp_next;
  int wr_next;

  initial begin
    idle();
    Data_in = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_state("reset");

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; Data_in = 16'(i);
      step();
      $display("write 0x%04h count=%0d", Data_in, count);
      check_eq($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      check_eq($sformatf("fill%0d_af", i), 32'(In_Almost_Full), (i >= 7) ? 1 : 0);
      check_eq($sformatf("fill%0d_ae", i), 32'(Out_Almost_Empty), (i <= 1) ? 1 : 0);
      check_eq($sformatf("fill%0d_full", i), 32'(In_Busy), (i == 8) ? 1 : 0);
    end

    // Write into full FIFO without a read is rejected.
    wr_en = 1'b1; Data_in = 16'h0099;
    step();
    $display("rejected write 0x0099 ovf=%0b", Overflow);
    check_eq("ovf_set", 32'(Overflow), 1);
    check_eq("ovf_count", 32'(count), 8);
    idle();
    step();
    check_eq("ovf_sticky", 32'(Overflow), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    $display("clr_err ovf=%0b", Overflow);
    check_eq("ovf_clear", 32'(Overflow), 0);
    check_eq("ovf_clear_count", 32'(count), 8);

    // Full with simultaneous read and write.
    wr_en = 1'b1; rd_en = 1'b1; Data_in = 16'h00AA;
    step();
    $display("full rd+wr dout=0x%04h valid=%0b count=%0d", Data_out, Data_valid, count);
    check_eq("fullrw_dout", 32'(Data_out), 32'h0001);
    check_eq("fullrw_valid", 32'(Data_valid), 1);
    check_eq("fullrw_count", 32'(count), 8);
    check_eq("fullrw_ovf", 32'(Overflow), 0);
    idle();
    step();
    check_eq("hold_valid", 32'(Data_valid), 0);
    check_eq("hold_dout", 32'(Data_out), 32'h0001);

    // Drain: 2..8 then 0x00AA.
    drain_exp = '{16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'hAA};
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      $display("read 0x%04h valid=%0b count=%0d", Data_out, Data_valid, count);
      check_eq($sformatf("drain%0d_dout", i), 32'(Data_out), 32'(drain_exp[i]));
      check_eq($sformatf("drain%0d_valid", i), 32'(Data_valid), 1);
    end
    idle();
    step();
    check_eq("drained_empty", 32'(Out_Busy), 1);
    check_eq("drained_unf", 32'(Underflow), 0);

    // Empty with simultaneous read and write.
    wr_en = 1'b1; rd_en = 1'b1; Data_in = 16'h0055;
    step();
    $display("empty rd+wr unf=%0b count=%0d valid=%0b", Underflow, count, Data_valid);
    check_eq("emptyrw_unf", 32'(Underflow), 1);
    check_eq("emptyrw_count", 32'(count), 1);
    check_eq("emptyrw_valid", 32'(Data_valid), 0);
    idle(); rd_en = 1'b1;
    step();
    $display("read 0x%04h valid=%0b", Data_out, Data_valid);
    check_eq("emptyrw_read", 32'(Data_out), 32'h0055);
    check_eq("emptyrw_read_valid", 32'(Data_valid), 1);
    idle(); clr_err = 1'b1; rd_en = 1'b1;
    step();
    check_eq("clr_vs_new_unf", 32'(Underflow), 1);
    idle(); clr_err = 1'b1;
    step();
    idle();
    check_eq("unf_clear", 32'(Underflow), 0);

    // Interleaved 12 writes/12 reads across the pointer wrap.
    exp_next = 1; wr_next = 1;
    for (int r = 1; r <= 6; r++) begin
      for (int k = 0; k < 2; k++) begin
        idle(); wr_en = 1'b1; Data_in = 16'(wr_next); wr_next++;
        step();
      end
      idle(); rd_en = 1'b1;
      step();
      $display("read 0x%04h valid=%0b count=%0d", Data_out, Data_valid, count);
      check_eq($sformatf("ilv%0d_dout", r), 32'(Data_out), 32'(exp_next));
      check_eq($sformatf("ilv%0d_count", r), 32'(count), 32'(r));
      exp_next++;
    end
    for (int i = 0; i < 6; i++) begin
      idle(); rd_en = 1'b1;
      step();
      $display("read 0x%04h valid=%0b count=%0d", Data_out, Data_valid, count);
      check_eq($sformatf("ilvdrain%0d_dout", i), 32'(Data_out), 32'(exp_next));
      exp_next++;
    end
    idle();
    step();
    check_eq("ilv_empty", 32'(Out_Busy), 1);
    check_eq("ilv_ovf", 32'(Overflow), 0);

    // Reset mid-stream with count = 5 and both requests high.
    rd_en = 1'b1;
    step();
    check_eq("pre_rst_unf", 32'(Underflow), 1);
    for (int i = 0; i < 5; i++) begin
      idle(); wr_en = 1'b1; Data_in = 16'(16'h0100 + i);
      step();
    end
    idle(); rd_en = 1'b1;
    step();
    check_eq("pre_rst_dout", 32'(Data_out), 32'h0100);
    idle(); wr_en = 1'b1;
    step();
    check_eq("pre_rst_count", 32'(count), 5);
    wr_en = 1'b1; rd_en = 1'b1; rst = 1'b1; Data_in = 16'hBEEF;
    step();
    $display("mid-stream reset count=%0d dout=0x%04h", count, Data_out);
    check_reset_state("midrst");

    // Pointers restart at slot 0 after reset.
    idle(); wr_en = 1'b1; Data_in = 16'h0077;
    step();
    idle(); rd_en = 1'b1;
    step();
    $display("read 0x%04h valid=%0b", Data_out, Data_valid);
    check_eq("post_rst_read", 32'(Data_out), 32'h0077);
    check_eq("post_rst_empty", 32'(Out_Busy), 1);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
